// File: rtl/ddr3_dmaster_ready_latency_adt.sv
// ddr3_dmaster_ready_latency_adt
// Avalon-ST timing adapter for the DDR3 control debug-master byte stream.
// The upstream side uses readyLatency = IN_READY_LATENCY. The downstream side
// uses readyLatency = 0.
// A small FIFO holds beats that are still in flight after in_ready drops.
// in_ready is issued conservatively. Each grant reserves one FIFO entry until
// its slot has passed, so a protocol-abiding upstream can never overrun the
// FIFO.
// Legal parameters: IN_READY_LATENCY in 1..4. DEPTH must be a power of two and
// at least IN_READY_LATENCY+1.

module ddr3_dmaster_ready_latency_adt #(
    parameter int DATA_WIDTH       = 8,
    parameter int IN_READY_LATENCY = 2,
    parameter int DEPTH            = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  overflow
);

    localparam int L     = IN_READY_LATENCY;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    // count (<= DEPTH) plus up to four outstanding grants
    localparam int SUM_W = CNT_W + 3;

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(DEPTH);

    // Number of grants still held in the history shift register.
    function automatic logic [SUM_W-1:0] popcount(input logic [L:1] v);
        logic [SUM_W-1:0] acc;
        acc = {SUM_W{1'b0}};
        for (int k = 1; k <= L; k++) begin
            acc = acc + SUM_W'(v[k]);
        end
        return acc;
    endfunction

    // Storage and control state
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [L:1]            hist_r;
    logic                  overflow_r;

    // Combinational decode
    logic [L:1]            hist_next_s;
    logic [SUM_W-1:0]      pending_s;
    logic [SUM_W-1:0]      occupancy_s;
    logic                  in_ready_s;
    logic                  out_valid_s;
    logic                  granted_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  proto_err_s;

    // Grant and handshake decode.
    // in_ready comes only from state and reset. Pops are not credited here,
    // which keeps the grant path free of any in_* or out_ready dependency.
    always_comb begin
        pending_s   = popcount(hist_r);
        occupancy_s = SUM_W'(count_r) + pending_s;
        in_ready_s  = !reset && (occupancy_s < DEPTH_SUM);

        // hist[L] marks the cycle in which an earlier grant becomes usable.
        granted_s   = hist_r[L];
        push_s      = !reset && in_valid && granted_s;
        proto_err_s = !reset && in_valid && !granted_s;

        out_valid_s = !reset && (count_r != {CNT_W{1'b0}});
        pop_s       = out_valid_s && out_ready;

        hist_next_s    = hist_r;
        hist_next_s[1] = in_ready_s;
        for (int k = 2; k <= L; k++) begin
            hist_next_s[k] = hist_r[k-1];
        end
    end

    // Pointer, occupancy, grant-history and sticky error state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            hist_r     <= {L{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            hist_r <= hist_next_s;

            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end

            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end

            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase

            // A beat outside a granted slot is dropped. The flag stays set
            // until the next reset.
            if (proto_err_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Payload storage. It is not reset, because empty entries are never shown.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = mem_r[rd_ptr_r];
    assign overflow  = overflow_r;

`ifndef SYNTHESIS
    // Debug aid: the grant rule must keep occupancy within the FIFO.
    p_count_bound: assert property (@(posedge clk) disable iff (reset)
        count_r <= CNT_W'(DEPTH));
`endif

endmodule

// File: tb/tb_ddr3_dmaster_ready_latency_adt.sv
// Testbench for ddr3_dmaster_ready_latency_adt.
// The bench uses three kinds of stimulus:
//   - a vector table for reset release and back-to-back streaming;
//   - hand-written sequences for fill, drain, illegal beats and mid-stream reset;
//   - a randomized phase.
// Every cycle is also compared against a reference model. The model keeps a
// per-cycle record of in_ready and an ordinary queue of stored beats.

module tb_ddr3_dmaster_ready_latency_adt;

    localparam int DW    = 8;
    localparam int L     = 2;
    localparam int DEPTH = 4;
    localparam int MAXC  = 4096;

    logic          clk = 1'b1;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          overflow;

    always #5 clk = ~clk;

    ddr3_dmaster_ready_latency_adt #(
        .DATA_WIDTH(DW),
        .IN_READY_LATENCY(L),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .overflow(overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    bit            m_ovf      = 1'b0;
    int            last_reset = -100;
    bit            rdy_at[MAXC];
    int            cyc        = 0;
    bit            model_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Count the grants issued in the last L cycles that no reset has cancelled.
    function automatic int pending_now();
        int p = 0;
        for (int s = cyc - L; s < cyc; s++) begin
            if (s >= 0 && s > last_reset && rdy_at[s]) p++;
        end
        return p;
    endfunction

    // The current cycle is a usable slot if in_ready was high exactly L cycles ago.
    function automatic bit granted_now();
        int s = cyc - L;
        return !reset && s >= 0 && s > last_reset && rdy_at[s];
    endfunction

    function automatic bit exp_ready();
        return !reset && ((mq.size() + pending_now()) < DEPTH);
    endfunction

    // Compare the current cycle against the model, then advance the model
    // across the next rising edge.
    task automatic finish_cycle();
        bit er, ev, g;
        er = exp_ready();
        ev = !reset && (mq.size() > 0);
        g  = granted_now();
        if (model_on) begin
            check("model_in_ready", in_ready, er);
            check("model_out_valid", out_valid, ev);
            if (ev) check("model_out_data", out_data, mq[0]);
            check("model_overflow", overflow, m_ovf);
        end
        if (cyc < MAXC) rdy_at[cyc] = er;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_ovf      = 1'b0;
            last_reset = cyc;
            model_on   = 1'b1;
        end else begin
            if (ev && out_ready) void'(mq.pop_front());
            if (in_valid && g) mq.push_back(in_data);
            else if (in_valid) m_ovf = 1'b1;
        end
        cyc++;
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        finish_cycle();
    endtask

    // Present a beat only in slots that the model says are granted.
    task automatic fill_granted(input int n, inout logic [DW-1:0] d);
        for (int i = 0; i < n; i++) begin
            in_valid = granted_now();
            in_data  = d;
            cycle();
            if (in_valid) d = d + 8'd1;
        end
        in_valid = 1'b0;
    endtask

    typedef struct {
        bit            iv;
        logic [DW-1:0] d;
        bit            ordy;
        bit            e_ir;
        bit            e_ov;
        logic [DW-1:0] e_od;
        bit            e_ovf;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic [DW-1:0] d;
        bit skip;

        // Streaming vectors: the first row is the first cycle after reset.
        // Beats 0x00..0x0F fill the granted slots starting in row 2. Each beat
        // appears on the output one row after it was pushed.
        for (int i = 0; i < 20; i++) begin
            tbl[i].iv    = (i >= 2 && i <= 17);
            tbl[i].d     = DW'(i - 2);
            tbl[i].ordy  = 1'b1;
            tbl[i].e_ir  = 1'b1;
            tbl[i].e_ov  = (i >= 3 && i <= 18);
            tbl[i].e_od  = DW'(i - 3);
            tbl[i].e_ovf = 1'b0;
        end

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_in_ready", in_ready, 1'b0);
            check("rst_out_valid", out_valid, 1'b0);
            finish_cycle();
        end
        reset = 1'b0;

        // Vector table: reset release and continuous streaming.
        for (int i = 0; i < 20; i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].d;
            out_ready = tbl[i].ordy;
            @(negedge clk);
            check("tbl_in_ready", in_ready, tbl[i].e_ir);
            check("tbl_out_valid", out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) check("tbl_out_data", out_data, tbl[i].e_od);
            check("tbl_overflow", overflow, tbl[i].e_ovf);
            finish_cycle();
        end
        in_valid = 1'b0;
        repeat (3) cycle();

        // Fill with no downstream accept: only four beats fit, then drain.
        out_ready = 1'b0;
        d = 8'h40;
        fill_granted(6, d);
        @(negedge clk);
        check("full_in_ready", in_ready, 1'b0);
        check("full_out_valid", out_valid, 1'b1);
        check("full_overflow", overflow, 1'b0);
        finish_cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_out_valid", out_valid, 1'b1);
            check("drain_out_data", out_data, 32'h40 + 32'(i));
            finish_cycle();
        end
        @(negedge clk);
        check("drained_out_valid", out_valid, 1'b0);
        check("drained_in_ready", in_ready, 1'b1);
        finish_cycle();
        repeat (2) cycle();

        // An ungranted beat 0xA5 is dropped and sets the sticky overflow flag.
        out_ready = 1'b0;
        d = 8'h50;
        fill_granted(6, d);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        check("illegal_overflow_before", overflow, 1'b0);
        finish_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("illegal_overflow_set", overflow, 1'b1);
        finish_cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("illegal_drain_data", out_data, 32'h50 + 32'(i));
            finish_cycle();
        end
        @(negedge clk);
        check("illegal_not_stored", out_valid, 1'b0);
        finish_cycle();
        d = 8'h60;
        fill_granted(12, d);
        @(negedge clk);
        check("overflow_sticky", overflow, 1'b1);
        finish_cycle();

        // Alternate granted slots are left empty.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        skip  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = 1'b0;
            if (granted_now()) begin
                in_valid = !skip;
                skip     = !skip;
            end
            in_data = DW'($urandom);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) cycle();

        // Mid-stream reset: stored and in-flight beats are discarded.
        out_ready = 1'b0;
        d = 8'h70;
        fill_granted(2, d);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h62;
        cycle();
        reset   = 1'b0;
        in_data = 8'h77;
        @(negedge clk);
        check("postrst_out_valid", out_valid, 1'b0);
        check("postrst_in_ready", in_ready, 1'b1);
        check("postrst_overflow", overflow, 1'b0);
        finish_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("postrst_stale_ovf", overflow, 1'b1);
        check("postrst_stale_drop", out_valid, 1'b0);
        finish_cycle();

        // Randomized traffic: mostly legal, with occasional illegal beats and resets.
        for (int i = 0; i < 300; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (granted_now()) in_valid = ($urandom_range(0, 3) != 0);
            else               in_valid = ($urandom_range(0, 49) == 0);
            in_data = DW'($urandom);
            cycle();
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
